// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL supervisor.
// State encodings are visible on the debug port, so their values are fixed.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    // Width needed to count 0 .. max(a,b,c)-1, never less than one bit.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_supervisor_sync_2ff.sv
// Generic single-bit two-flop synchroniser, synchronous reset to 0.
// Used to bring the asynchronous PLL lock indicator into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] stage_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_reg <= 2'b00;
        end else begin
            stage_reg <= {stage_reg[0], d};
        end
    end

    assign q = stage_reg[1];

endmodule

// File: rtl/pll_supervisor.sv
// PLL reset sequencer and lock supervisor: holds the system reset until lock
// has been stable for a settle period, retries on timeout, and latches FAIL.
module pll_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int SETTLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [LOSS_W-1:0]  loss_cnt,
    output logic [2:0]         state
);

    localparam int TIMER_W = timer_width(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);

    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);
    localparam logic [LOSS_W-1:0]  LOSS_MAX     = '1;

    logic lock_s;

    state_t             state_reg, state_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic [RETRY_W-1:0] retry_reg, retry_next;
    logic [LOSS_W-1:0]  loss_reg, loss_next;
    logic               pll_rst_reg, sys_rst_reg, ready_reg, fail_reg;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg + 1'b1;
        retry_next = retry_reg;
        loss_next  = loss_reg;
        case (state_reg)
            ST_PLL_RST: begin
                if (timer_reg == RST_LAST) state_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // Lock is tested first so a lock arriving on the timeout cycle wins.
                if (lock_s) begin
                    state_next = ST_SETTLE;
                end else if (timer_reg == TIMEOUT_LAST) begin
                    if (retry_reg == RETRY_LIMIT) begin
                        state_next = ST_FAIL;
                    end else begin
                        retry_next = retry_reg + 1'b1;
                        state_next = ST_PLL_RST;
                    end
                end
            end
            ST_SETTLE: begin
                if (!lock_s) begin
                    state_next = ST_WAIT_LOCK;
                end else if (timer_reg == SETTLE_LAST) begin
                    state_next = ST_RUN;
                    retry_next = '0;
                end
            end
            ST_RUN: begin
                timer_next = '0;
                if (!lock_s) begin
                    if (loss_reg != LOSS_MAX) loss_next = loss_reg + 1'b1;
                    state_next = ST_PLL_RST;
                end
            end
            ST_FAIL: begin
                timer_next = '0;
            end
            default: begin
                state_next = ST_PLL_RST;
            end
        endcase
        // One shared timer: every state starts counting from zero.
        if (state_next != state_reg) timer_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_PLL_RST;
            timer_reg   <= '0;
            retry_reg   <= '0;
            loss_reg    <= '0;
            pll_rst_reg <= 1'b1;
            sys_rst_reg <= 1'b1;
            ready_reg   <= 1'b0;
            fail_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            retry_reg   <= retry_next;
            loss_reg    <= loss_next;
            // Outputs are registered copies of the decode of the next state.
            pll_rst_reg <= (state_next == ST_PLL_RST) || (state_next == ST_FAIL);
            sys_rst_reg <= (state_next != ST_RUN);
            ready_reg   <= (state_next == ST_RUN);
            fail_reg    <= (state_next == ST_FAIL);
        end
    end

    assign pll_rst   = pll_rst_reg;
    assign sys_rst   = sys_rst_reg;
    assign ready     = ready_reg;
    assign fail      = fail_reg;
    assign retry_cnt = retry_reg;
    assign loss_cnt  = loss_reg;
    assign state     = state_reg;

endmodule

// File: tb/tb_pll_supervisor.sv
// Bench for pll_supervisor: directed scenarios with literal expectations plus
// random lock activity, all checked every cycle against a phase/delay-line model.
module tb_pll_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int SETTLE_CYCLES = 8;
    localparam int MAX_RETRY     = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst, sys_rst, ready, fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    pll_supervisor #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .MAX_RETRY     (MAX_RETRY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    endtask

    // Reference model: phase number, edges spent in the phase, and a two-deep
    // delay line standing in for the synchroniser.
    int m_phase, m_elapsed, m_retry, m_loss;
    bit m_valid = 1'b0;
    bit m_hist[$];

    task automatic enter(input int p);
        m_phase   = p;
        m_elapsed = 0;
    endtask

    task automatic model_step();
        bit ls;
        if (rst) begin
            m_phase = 0; m_elapsed = 0; m_retry = 0; m_loss = 0;
            m_hist.delete();
            m_hist.push_back(1'b0);
            m_hist.push_back(1'b0);
            m_valid = 1'b1;
        end else if (m_valid) begin
            ls = m_hist.pop_front();
            m_hist.push_back(pll_locked);
            m_elapsed++;
            case (m_phase)
                0: if (m_elapsed == RST_CYCLES) enter(1);
                1: begin
                    if (ls) enter(2);
                    else if (m_elapsed == LOCK_TIMEOUT) begin
                        if (m_retry == MAX_RETRY) enter(4);
                        else begin m_retry++; enter(0); end
                    end
                end
                2: begin
                    if (!ls) enter(1);
                    else if (m_elapsed == SETTLE_CYCLES) begin m_retry = 0; enter(3); end
                end
                3: if (!ls) begin
                    if (m_loss < 255) m_loss++;
                    enter(0);
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] model_vec();
        logic [2:0] ph;
        logic [3:0] rc;
        logic [7:0] lc;
        ph = 3'(m_phase);
        rc = 4'(m_retry);
        lc = 8'(m_loss);
        return {13'd0, ph, (m_phase == 0 || m_phase == 4), (m_phase != 3),
                (m_phase == 3), (m_phase == 4), rc, lc};
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid)
            check("model", {13'd0, state, pll_rst, sys_rst, ready, fail, retry_cnt, loss_cnt}, model_vec());
    end

    function automatic logic pick(input int which);
        case (which)
            0: return pll_rst;
            1: return sys_rst;
            2: return ready;
            3: return fail;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input string name, input int which, input logic val,
                            input int limit, output int edges);
        edges = 0;
        while (pick(which) !== val && edges < limit) begin
            @(negedge clk);
            edges++;
        end
        if (pick(which) !== val) check({name, "_timeout"}, 32'(pick(which)), 32'(val));
    endtask

    task automatic wait_state(input string name, input logic [2:0] s, input int limit);
        int edges;
        edges = 0;
        while (state !== s && edges < limit) begin
            @(negedge clk);
            edges++;
        end
        if (state !== s) check({name, "_timeout"}, 32'(state), 32'(s));
    endtask

    task automatic do_reset(input logic lock_val);
        @(negedge clk);
        rst = 1'b1;
        pll_locked = lock_val;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int e;
        int cnt;

        // Clean start, then a loss in RUN and recovery.
        do_reset(1'b0);
        wait_sig("pll_rst_low", 0, 1'b0, 50, e);
        check("pll_rst_high_cycles", e, 4);
        repeat (6) @(negedge clk);
        pll_locked = 1'b1;
        wait_sig("release", 1, 1'b0, 100, e);
        check("lock_to_release", e, 11);
        check("clean_ready", ready, 1);
        check("clean_retry", retry_cnt, 0);
        check("model_pin_run", m_phase, 3);
        $display("clean_start: release %0d edges after lock", e);

        pll_locked = 1'b0;
        wait_sig("loss_sys_rst", 1, 1'b1, 20, e);
        check("loss_latency", e, 3);
        check("loss_ready", ready, 0);
        check("loss_pll_rst", pll_rst, 1);
        check("loss_cnt_1", loss_cnt, 1);
        check("loss_state", state, 0);
        pll_locked = 1'b1;
        wait_sig("loss_recover", 2, 1'b1, 100, e);
        check("recover_state", state, 3);
        $display("run_loss: recovered after %0d edges, loss_cnt=%0d", e, loss_cnt);

        // Glitch at SETTLE count 5.
        do_reset(1'b1);
        wait_state("glitch_settle", 3'd2, 50);
        repeat (5) @(negedge clk);
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        pll_locked = 1'b1;
        @(negedge clk);
        check("glitch_wait_lock", state, 1);
        check("glitch_retry", retry_cnt, 0);
        wait_sig("glitch_release", 1, 1'b0, 100, e);
        check("glitch_release_edges", e + 1, 11);
        $display("settle_glitch: release %0d edges after lock returned", e + 1);

        // Lock arrives on the exact timeout cycle.
        do_reset(1'b0);
        repeat (21) @(negedge clk);
        pll_locked = 1'b1;
        repeat (2) @(negedge clk);
        check("tie_pre", state, 1);
        @(negedge clk);
        check("tie_state", state, 2);
        check("tie_retry", retry_cnt, 0);
        $display("timeout_tie: state=%0d", state);

        // Never lock: three timeouts then FAIL, sticky even if lock appears.
        do_reset(1'b0);
        wait_sig("fail_entry", 3, 1'b1, 200, e);
        check("fail_entry_edges", e, 72);
        check("fail_retry", retry_cnt, 2);
        check("fail_state", state, 4);
        check("model_pin_fail", m_phase, 4);
        pll_locked = 1'b1;
        cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (state == 3'd4 && fail && pll_rst && sys_rst) cnt++;
        end
        check("fail_hold", cnt, 200);
        rst = 1'b1;
        @(negedge clk);
        check("fail_rst_state", state, 0);
        check("fail_rst_fail", fail, 0);
        rst = 1'b0;
        $display("never_lock: fail after %0d edges", e);

        // Loss counter saturation.
        do_reset(1'b1);
        wait_sig("sat_ready", 2, 1'b1, 100, e);
        for (int i = 0; i < 260; i++) begin
            pll_locked = 1'b0;
            wait_sig("sat_drop", 1, 1'b1, 10, e);
            pll_locked = 1'b1;
            wait_sig("sat_recover", 2, 1'b1, 100, e);
        end
        check("loss_saturate", loss_cnt, 255);
        check("model_pin_loss", m_loss, 255);
        $display("loss_saturation: loss_cnt=%0d", loss_cnt);

        // rst mid-SETTLE returns every output to its reset value.
        pll_locked = 1'b0;
        wait_state("mid_pllrst", 3'd0, 10);
        pll_locked = 1'b1;
        wait_state("mid_settle", 3'd2, 50);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_state", state, 0);
        check("midrst_pll_rst", pll_rst, 1);
        check("midrst_sys_rst", sys_rst, 1);
        check("midrst_ready", ready, 0);
        check("midrst_fail", fail, 0);
        check("midrst_retry", retry_cnt, 0);
        check("midrst_loss", loss_cnt, 0);
        rst = 1'b0;
        $display("rst_mid_settle: state=%0d loss_cnt=%0d", state, loss_cnt);

        // Random lock activity with occasional reset pulses.
        do_reset(1'b0);
        for (int i = 0; i < 300; i++) begin
            pll_locked = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 40)) @(negedge clk);
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        $display("random: state=%0d retry_cnt=%0d loss_cnt=%0d", state, retry_cnt, loss_cnt);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pll_supervisor.md
# pll_supervisor

Sequences and supervises the system PLL from the free-running reference clock. Drives the PLL's reset input and consumes its asynchronous `locked` output. Holds the system reset until lock has been stable for a settle period, re-acquires lock automatically on loss, and gives up after a bounded number of failed attempts. Sits between the PLL wrapper and every consumer of the system reset.

## Interface
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥1)
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK before an attempt fails (1 ms at 50 MHz, ≥2)
- `SETTLE_CYCLES`, 1024: consecutive locked cycles required before release (≥1)
- `MAX_RETRY`, 7: failed attempts tolerated before FAIL (0..15)

Ports:
- `clk`  in  1  50 MHz reference clock, the same clock the PLL uses as reference
- `rst`  in  1  reset; synchronous, active-high
- `pll_locked`  in  1  PLL lock indicator, asynchronous to `clk`
- `pll_rst`  out  1  reset to the PLL
- `sys_rst`  out  1  system reset; consumers resynchronise it into their own domain
- `ready`  out  1  high only in RUN
- `fail`  out  1  high only in FAIL
- `retry_cnt`  out  4  failed attempts since last RUN entry or `rst`
- `loss_cnt`  out  8  lock losses while in RUN, saturating at 255
- `state`  out  3  current state encoding, for debug

## Operation
- `pll_locked` passes through a 2-FF synchroniser to give `lock_s`. No other logic samples `pll_locked`.
- All outputs decode from registered state and counters (Moore). `sys_rst` is high in every state except RUN.
- States and encodings:
  - PLL_RST=0: `pll_rst`=1. The timer counts to RST_CYCLES-1, then the block goes to WAIT_LOCK and clears the timer.
  - WAIT_LOCK=1: `pll_rst`=0.
    - If `lock_s`=1, go to SETTLE and clear the timer.
    - Otherwise, when the timer reaches LOCK_TIMEOUT-1: if `retry_cnt`==MAX_RETRY, go to FAIL; else increment `retry_cnt` and go to PLL_RST.
    - If `lock_s` rises in the same cycle as the timeout, lock wins.
  - SETTLE=2: the timer increments while `lock_s`=1.
    - If `lock_s`=0, go to WAIT_LOCK, clear the timer, and leave `retry_cnt` unchanged.
    - When the timer reaches SETTLE_CYCLES-1 with `lock_s`=1, go to RUN.
  - RUN=3: `ready`=1, `sys_rst`=0. `retry_cnt` clears on entry. If `lock_s`=0, increment `loss_cnt` (saturating) and go to PLL_RST.
  - FAIL=4: `pll_rst`=1, `sys_rst`=1, `fail`=1. The only exit is `rst`.
- Reset values: state=PLL_RST, timer=0, `pll_rst`=1, `sys_rst`=1, `ready`=0, `fail`=0, `retry_cnt`=0, `loss_cnt`=0, synchroniser flops=0.
- `rst` asserted in any state, including mid-SETTLE or FAIL, returns everything to reset values on the next edge.
- The timer is wide enough for max(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES). It is shared by all states and cleared on every state change.

## Timing
- `pll_rst` is high for exactly RST_CYCLES cycles after `rst` deasserts, and for RST_CYCLES cycles on each retry.
- Lock-to-release latency: with `pll_locked` high before edge 1 and held stable, `lock_s` is high after edge 2, SETTLE is entered at edge 3, and `sys_rst` falls at edge SETTLE_CYCLES+3.
- Loss latency: with `pll_locked` low before edge 1, `sys_rst` rises and `ready` falls after edge 3. `pll_rst` also rises after edge 3.
- A `pll_locked` glitch shorter than one cycle may be missed. Any glitch that is captured restarts SETTLE through WAIT_LOCK.

## Structure
- Package `pll_sup_pkg` holds the state enum and encodings (0..4) plus a `clog2`-based timer width function.
- Sub-module `sync_2ff` is a generic single-bit 2-flop synchroniser with synchronous reset to 0. It is reused for `lock_s`.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8, MAX_RETRY=2.
- Clean start: raise `pll_locked` 10 cycles after `rst` release. Expect `pll_rst` high for 4 cycles, `sys_rst` falling 11 edges after lock, `ready`=1, `retry_cnt`=0.
- Never lock: hold `pll_locked`=0. Expect 3 timeouts, `retry_cnt` 1→2, then FAIL with `fail`=1, `pll_rst`=1, `state`=4 held for 200 cycles. Assert `rst`: back to state 0.
- Settle glitch: drop `pll_locked` for 2 cycles at SETTLE count 5. Expect a return to WAIT_LOCK, `retry_cnt` unchanged, and release 8 settle cycles after lock returns.
- Run loss: drop `pll_locked` in RUN. Expect `sys_rst` high after 3 edges, `loss_cnt`=1, PLL_RST re-entered, and recovery to RUN.
- Timeout tie: raise `lock_s` on the exact timeout cycle. Expect SETTLE, not PLL_RST.
- `loss_cnt` saturation: 260 losses give `loss_cnt`=255. `rst` mid-SETTLE clears all outputs to their reset values.
